// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;
  localparam int UART_MAX_BYTES = 8;
  localparam int UART_LEN_W     = 4;
  localparam int UART_DATA_W    = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_FINISH
  } arb_state_t;

  typedef struct packed {
    logic [UART_DATA_W-1:0] data;
    logic [UART_LEN_W-1:0]  len;
  } tx_req_t;

  // The engine only has eight byte slots, so longer counts saturate.
  function automatic logic [UART_LEN_W-1:0] clamp_len(input logic [UART_LEN_W-1:0] len);
    return (len > UART_LEN_W'(UART_MAX_BYTES)) ? UART_LEN_W'(UART_MAX_BYTES) : len;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational winner select: round-robin from ptr, or fixed priority
// (index 0 highest) when UART_TX_ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan high to low so the lowest set index is the last (winning) write.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        win    = '0;
        win[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end
`else
  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        found  = 1'b1;
        win[k] = 1'b1;
        idx    = k;
      end
    end
  end
`endif
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit engine among N_REQ requesters.
// Build option: UART_TX_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int START_TO = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  input  logic [UART_LEN_W*N_REQ-1:0]  req_len,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             done,
  output logic                         err,
  output logic                         tx_sig,
  output logic [UART_DATA_W-1:0]       tx_data,
  output logic [UART_LEN_W-1:0]        tx_len,
  input  logic                         tx_busy
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(START_TO + 1);

  arb_state_t     state, nxt;
  logic [N_REQ-1:0] win, win_q;
  logic [IW-1:0]  win_idx, idx_q, ptr;
  logic           zero_q;
  logic [CW-1:0]  to_cnt;
  tx_req_t        sel;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .idx (win_idx)
  );

  assign sel.data = req_data[win_idx*UART_DATA_W +: UART_DATA_W];
  assign sel.len  = clamp_len(req_len[win_idx*UART_LEN_W +: UART_LEN_W]);

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  logic unused_idx;
  assign unused_idx = ^idx_q;
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr <= '0;
    else if (state == S_FINISH) ptr <= (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
  end
`endif

  // tx_data/tx_len only load for real frames, so they hold across a skipped
  // zero-length grant and never change while the engine shifts a frame out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= '0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
      tx_data <= '0;
      tx_len  <= '0;
    end else if (state == S_IDLE && |req) begin
      win_q  <= win;
      idx_q  <= win_idx;
      zero_q <= (sel.len == '0);
      if (sel.len != '0) begin
        tx_data <= sel.data;
        tx_len  <= sel.len;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    to_cnt <= '0;
    else if (state == S_WAIT_START) to_cnt <= to_cnt + 1'b1;
    else                           to_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:       if (|req) nxt = S_ISSUE;
      S_ISSUE:      nxt = zero_q ? S_FINISH : S_WAIT_START;
      S_WAIT_START: begin
        if (tx_busy)                              nxt = S_WAIT_DONE;
        else if (to_cnt == CW'(START_TO - 1))     nxt = S_FINISH;
      end
      S_WAIT_DONE:  if (!tx_busy) nxt = S_FINISH;
      S_FINISH:     nxt = S_IDLE;
      default:      nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt    = '0;
    done   = '0;
    tx_sig = 1'b0;
    err    = 1'b0;
    unique case (state)
      S_ISSUE: begin
        gnt    = win_q;
        tx_sig = !zero_q;
      end
      S_WAIT_START: err  = !tx_busy && (to_cnt == CW'(START_TO - 1));
      S_FINISH:     done = win_q;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a one-byte-per-cycle transmitter model.
module tb_uart_tx_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [255:0] req_data = '0;
  logic [15:0]  req_len = '0;
  logic [3:0]   gnt, done;
  logic         err, tx_sig;
  logic [63:0]  tx_data;
  logic [3:0]   tx_len;
  logic         tx_busy = 1'b0;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit auto_tx = 1'b1;
  int tx_n;
  logic [7:0] sent[$];

  uart_tx_arbiter #(.N_REQ(4), .START_TO(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_len(req_len),
    .gnt(gnt), .done(done), .err(err), .tx_sig(tx_sig), .tx_data(tx_data),
    .tx_len(tx_len), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy from the cycle after tx_sig, one cycle per byte, MSB byte first.
  initial forever begin
    @(negedge clk);
    if (auto_tx && tx_sig) begin
      tx_n = int'(tx_len);
      @(posedge clk); #1 tx_busy = 1'b1;
      for (int b = tx_n - 1; b >= 0; b--) begin
        sent.push_back(tx_data[8*b +: 8]);
        @(posedge clk); #1;
      end
      tx_busy = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_gnt(input string tag, input logic [3:0] exp, output int t);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    t = cyc;
    chk(tag, gnt, exp);
  endtask

  // Returns at the negedge of the done cycle; checks done is one cycle after busy falls.
  task automatic wait_fall(input string tag, input logic [3:0] exp, output int t);
    int i;
    i = 0;
    while (!tx_busy && i < 50)  begin @(negedge clk); i++; end
    while (tx_busy && i < 100) begin @(negedge clk); i++; end
    chk({tag, "_early"}, done, 4'b0);
    @(negedge clk);
    t = cyc;
    chk(tag, done, exp);
  endtask

  logic [3:0]  rr_exp [4];
  logic [63:0] acc;
  int tg, td, last_done, errs;

  initial begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`endif
    repeat (2) @(negedge clk);
    chk("reset_ctl", {gnt, done, err, tx_sig, tx_len}, '0);
    chk("reset_data", tx_data, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Round-robin with three requesters held, len 1 each.
    req_len = 16'h1111;
    req = 4'b1011;
    last_done = 0;
    for (int g = 0; g < 4; g++) begin
      wait_gnt($sformatf("rr_gnt%0d", g), rr_exp[g], tg);
      chk("rr_sig", tx_sig, 1'b1);
      if (g > 0) chk("rr_gap", 64'(tg - last_done), 64'd2);
      if (g == 3) req = '0;
      wait_fall("rr_done", rr_exp[g], last_done);
    end

    // Single requester, two bytes.
    sent.delete();
    req_data[64*2 +: 64] = 64'h0000_0000_0000_4142;
    req_len[4*2 +: 4] = 4'd2;
    req = 4'b0100;
    wait_gnt("single_gnt", 4'b0100, tg);
    chk("single_sig", tx_sig, 1'b1);
    chk("single_len", tx_len, 4'd2);
    req = '0;
    wait_fall("single_done", 4'b0100, td);
    chk("single_bytes", {48'b0, sent[0], sent[1]}, 64'h4142);

    // Zero-length skip on requester 1.
    req_len[4*1 +: 4] = 4'd0;
    req = 4'b0010;
    wait_gnt("zero_gnt", 4'b0010, tg);
    chk("zero_nosig", tx_sig, 1'b0);
    req = '0;
    @(negedge clk);
    chk("zero_done", {done, tx_sig}, {4'b0010, 1'b0});

    // Length 12 clamps to 8 bytes.
    sent.delete();
    req_data[64*2 +: 64] = 64'h0102_0304_0506_0708;
    req_len[4*2 +: 4] = 4'd12;
    req = 4'b0100;
    wait_gnt("clamp_gnt", 4'b0100, tg);
    chk("clamp_len", tx_len, 4'd8);
    req = '0;
    wait_fall("clamp_done", 4'b0100, td);
    acc = '0;
    foreach (sent[i]) acc = {acc[55:0], sent[i]};
    chk("clamp_count", 64'(sent.size()), 64'd8);
    chk("clamp_bytes", acc, 64'h0102_0304_0506_0708);

    // Start timeout: engine never goes busy.
    auto_tx = 1'b0;
    req_len = 16'h1111;
    req = 4'b0001;
    wait_gnt("to_gnt", 4'b0001, tg);
    req = '0;
    errs = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (err) errs++;
    end
    chk("to_early_err", 64'(errs), 64'd0);
    @(negedge clk);
    chk("to_err", {err, done}, {1'b1, 4'b0000});
    @(negedge clk);
    chk("to_done", {err, done}, {1'b0, 4'b0001});
    auto_tx = 1'b1;

    // Reset during WAIT_DONE.
    req_len[4*3 +: 4] = 4'd8;
    req = 4'b1000;
    wait_gnt("rst_gnt", 4'b1000, tg);
    req = '0;
    repeat (4) @(negedge clk);
    chk("rst_busy", tx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", {gnt, done, err, tx_sig, tx_len}, '0);
    chk("rst_data", tx_data, '0);
    @(negedge clk);
    chk("rst_nodone", done, 4'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 20 && tx_busy; i++) @(negedge clk);
    @(negedge clk);

    // Fresh request after reset: pointer back at 0, then keep both held.
    req_len = 16'h1111;
    req = 4'b1001;
    wait_gnt("post_rst_gnt", 4'b0001, tg);
    wait_fall("post_rst_done", 4'b0001, td);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    wait_gnt("prio_gnt1", 4'b0001, tg);
    wait_fall("prio_done1", 4'b0001, td);
    wait_gnt("prio_gnt2", 4'b0001, tg);
    req = '0;
    wait_fall("prio_done2", 4'b0001, td);
`else
    wait_gnt("rr2_gnt1", 4'b1000, tg);
    wait_fall("rr2_done1", 4'b1000, td);
    wait_gnt("rr2_gnt2", 4'b0001, tg);
    req = '0;
    wait_fall("rr2_done2", 4'b0001, td);
`endif
    repeat (3) @(negedge clk);
    chk("final_idle", {gnt, done, err, tx_sig}, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
